// File: rtl/irq_ctrl_if.sv
// Ibex data-bus port bundle shared by every memory-mapped peripheral.
// The master drives the request; the slave answers with grant and a one-cycle-later response.
interface ibex_data_bus;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned INTG_W = 7;

  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [INTG_W-1:0] rdata_intg;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err,
    input  rdata_intg
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata,
    output err,
    output rdata_intg
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level capture, enable mask, W1C pending bits and a
// priority claim register; drives the single registered external interrupt to the core.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ibex_data_bus.slave        data_bus,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 12;
  localparam int unsigned ID_W   = 5;
  localparam int unsigned INTG_W = 7;

  localparam logic [OFF_W-1:0] OFF_MODE  = OFF_W'(12'h000);
  localparam logic [OFF_W-1:0] OFF_IER   = OFF_W'(12'h004);
  localparam logic [OFF_W-1:0] OFF_IPR   = OFF_W'(12'h008);
  localparam logic [OFF_W-1:0] OFF_CLAIM = OFF_W'(12'h00C);
  localparam logic [OFF_W-1:0] OFF_RAW   = OFF_W'(12'h010);

  if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_bad_num_irq
    $error("irq_ctrl: NUM_IRQ must be in 1..32");
  end

  // Registered state
  logic [NUM_IRQ-1:0] r_src_q;
  logic [NUM_IRQ-1:0] r_src_prev;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_ier;
  logic [NUM_IRQ-1:0] r_ipr;
  logic               r_irq;
  logic               r_rvalid;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;

  // Combinational nets
  logic [OFF_W-1:0]   w_off;
  logic               w_off_ok;
  logic               w_wr;
  logic               w_rd;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_act;
  logic               w_claim_vld;
  logic [ID_W-1:0]    w_claim_id;
  logic [NUM_IRQ-1:0] w_claim_oh;
  logic [DATA_W-1:0]  w_claim_word;
  logic [NUM_IRQ-1:0] w_claim_clr;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_ipr_nxt;
  logic [DATA_W-1:0]  w_rd_sel;
  logic               w_unused;

  // Address decode; upper address bits are resolved by the bus fabric.
  assign w_off    = data_bus.addr[OFF_W-1:0];
  assign w_off_ok = (w_off[1:0] == 2'b00) && (w_off <= OFF_RAW);
  assign w_wr     = data_bus.req &&  data_bus.we && w_off_ok;
  assign w_rd     = data_bus.req && !data_bus.we && w_off_ok;
  assign w_unused = ^{data_bus.addr[DATA_W-1:OFF_W], data_bus.wdata};

  assign w_rise = r_src_q & ~r_src_prev;
  assign w_act  = r_ipr & r_ier;

  // Lowest active index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    w_claim_vld = 1'b0;
    w_claim_id  = '0;
    w_claim_oh  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_claim_vld   = 1'b1;
        w_claim_id    = ID_W'(i);
        w_claim_oh    = '0;
        w_claim_oh[i] = 1'b1;
      end
    end
  end

  assign w_claim_word = {w_claim_vld, {(DATA_W-1-ID_W){1'b0}}, w_claim_id};

  // Only a granted CLAIM read of an edge-mode source consumes the pending bit.
  assign w_claim_clr = (w_rd && (w_off == OFF_CLAIM)) ? (w_claim_oh & r_mode) : '0;
  assign w_w1c       = (w_wr && (w_off == OFF_IPR)) ? data_bus.wdata[NUM_IRQ-1:0] : '0;

  // Edge bits: set beats clear. Level bits: track the synchronised source.
  assign w_ipr_nxt = (r_mode & (w_rise | (r_ipr & ~(w_w1c | w_claim_clr))))
                   | (~r_mode & r_src_q);

  always_comb begin
    w_rd_sel = r_rdata;
    case (w_off)
      OFF_MODE:  w_rd_sel = DATA_W'(r_mode);
      OFF_IER:   w_rd_sel = DATA_W'(r_ier);
      OFF_IPR:   w_rd_sel = DATA_W'(r_ipr);
      OFF_CLAIM: w_rd_sel = w_claim_word;
      OFF_RAW:   w_rd_sel = DATA_W'(r_src_q);
      default:   w_rd_sel = r_rdata;
    endcase
  end

  // Input synchroniser stage and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_q    <= '0;
      r_src_prev <= '0;
    end else begin
      r_src_q    <= irq_src;
      r_src_prev <= r_src_q;
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= '0;
      r_ier  <= '0;
    end else if (w_wr) begin
      if (w_off == OFF_MODE) r_mode <= data_bus.wdata[NUM_IRQ-1:0];
      if (w_off == OFF_IER)  r_ier  <= data_bus.wdata[NUM_IRQ-1:0];
    end
  end

  // Pending bits and the registered request to the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ipr <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ipr <= w_ipr_nxt;
      r_irq <= |w_act;
    end
  end

  // Bus response, one cycle after the granted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= data_bus.req;
      r_err    <= data_bus.req && !w_off_ok;
      if (w_rd) r_rdata <= w_rd_sel;
    end
  end

  assign data_bus.gnt        = data_bus.req;
  assign data_bus.rvalid     = r_rvalid;
  assign data_bus.err        = r_err;
  assign data_bus.rdata      = r_rdata;
  assign data_bus.rdata_intg = INTG_W'(0);
  assign irq                 = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access, edge/level capture, priority claim, masking
// and bus errors, with hand-computed expectations.
module tb_irq_ctrl;

  localparam int unsigned NUM_IRQ = 8;

  localparam logic [31:0] A_MODE  = 32'h000;
  localparam logic [31:0] A_IER   = 32'h004;
  localparam logic [31:0] A_IPR   = 32'h008;
  localparam logic [31:0] A_CLAIM = 32'h00C;
  localparam logic [31:0] A_RAW   = 32'h010;

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_src;
  logic               irq;

  int n_cmp;
  int n_err;

  ibex_data_bus bus ();

  irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_bus (bus),
    .irq_src  (irq_src),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_acc(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic rv, output logic er);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.we  = 1'b0;
    rd = bus.rdata;
    rv = bus.rvalid;
    er = bus.err;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        rv, er;
    bus_acc(1'b1, a, d, rd, rv, er);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        rv, er;
    bus_acc(1'b0, a, 32'h0, rd, rv, er);
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rv, er;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    irq_src   = 8'hFF;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset held with all sources high
    repeat (3) step();
    chk("rst_irq",    32'(irq),        32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_err",    32'(bus.err),    32'h0);
    chk("rst_rdata",  bus.rdata,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    rd_chk("rst_raw", A_RAW, 32'h0000_00FF);
    rd_chk("rst_ipr", A_IPR, 32'h0000_00FF);
    chk("rst_irq_ier0", 32'(irq), 32'h0);

    irq_src = '0;
    repeat (3) step();

    // Edge mode and priority
    wr(A_MODE, 32'hFF);
    wr(A_IER,  32'h14);
    @(negedge clk); irq_src = 8'h10;
    step(); chk("edge_irq_c0", 32'(irq), 32'h0);
    @(negedge clk); irq_src = 8'h04;
    step(); chk("edge_irq_c1", 32'(irq), 32'h0);
    @(negedge clk); irq_src = 8'h00;
    step(); chk("edge_irq_c2", 32'(irq), 32'h1);
    rd_chk("claim1", A_CLAIM, 32'h8000_0002);
    rd_chk("claim2", A_CLAIM, 32'h8000_0004);
    chk("edge_irq_after_claim2", 32'(irq), 32'h1);
    rd_chk("claim3", A_CLAIM, 32'h0000_0000);
    chk("edge_irq_fall", 32'(irq), 32'h0);

    // Simultaneous rising edge and W1C on source 0
    wr(A_IER, 32'h01);
    @(negedge clk); irq_src = 8'h01;
    @(negedge clk); irq_src = 8'h00;
    step();
    step();
    chk("se_irq_pre", 32'(irq), 32'h1);
    @(negedge clk); irq_src = 8'h01;
    step();
    irq_src = 8'h00;
    wr(A_IPR, 32'h01);
    chk("se_irq_at", 32'(irq), 32'h1);
    rd_chk("se_ipr", A_IPR, 32'h01);
    chk("se_irq_post", 32'(irq), 32'h1);
    wr(A_IPR, 32'h01);
    rd_chk("se_ipr_clr", A_IPR, 32'h00);

    // Level mode ignores W1C and claim
    irq_src = 8'h01;
    wr(A_MODE, 32'h00);
    wr(A_IER,  32'h01);
    step();
    step();
    wr(A_IPR, 32'h01);
    rd_chk("lvl_ipr",    A_IPR,   32'h01);
    rd_chk("lvl_claim1", A_CLAIM, 32'h8000_0000);
    rd_chk("lvl_claim2", A_CLAIM, 32'h8000_0000);
    chk("lvl_irq_hi", 32'(irq), 32'h1);
    @(negedge clk); irq_src = 8'h00;
    step(); chk("lvl_irq_d0", 32'(irq), 32'h1);
    step(); chk("lvl_irq_d1", 32'(irq), 32'h1);
    step(); chk("lvl_irq_d2", 32'(irq), 32'h0);

    // Mask: pending source 3 held off until enabled
    wr(A_IER,  32'h00);
    wr(A_MODE, 32'h08);
    @(negedge clk); irq_src = 8'h08;
    @(negedge clk); irq_src = 8'h00;
    step();
    step();
    chk("mask_irq_off", 32'(irq), 32'h0);
    rd_chk("mask_claim", A_CLAIM, 32'h0);
    rd_chk("mask_ipr",   A_IPR,   32'h08);
    wr(A_IER, 32'h08);
    chk("mask_irq_w0", 32'(irq), 32'h0);
    step();
    chk("mask_irq_w1", 32'(irq), 32'h1);

    // Bus errors
    rd_chk("err_pre_ipr", A_IPR, 32'h08);
    bus_acc(1'b0, 32'h014, 32'h0, rd, rv, er);
    chk("err014_err",   32'(er), 32'h1);
    chk("err014_rv",    32'(rv), 32'h1);
    chk("err014_hold",  rd,      32'h08);
    bus_acc(1'b0, 32'h100, 32'h0, rd, rv, er);
    chk("err100_err",   32'(er), 32'h1);
    chk("err100_rv",    32'(rv), 32'h1);
    bus_acc(1'b1, A_CLAIM, 32'hFFFF_FFFF, rd, rv, er);
    chk("wclaim_err",   32'(er), 32'h0);
    chk("wclaim_rv",    32'(rv), 32'h1);
    rd_chk("wclaim_ipr",  A_IPR,  32'h08);
    rd_chk("wclaim_mode", A_MODE, 32'h08);
    rd_chk("wclaim_ier",  A_IER,  32'h08);
    chk("wclaim_irq", 32'(irq), 32'h1);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("arst_ier", A_IER, 32'h0);
    rd_chk("arst_ipr", A_IPR, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
